// File: rtl/ppu_timing_pkg.sv
// Shared raster timing constants (NTSC and PAL builds), counter width and helpers
// used by the PPU video timing sequencer and its raster counter.
package ppu_timing_pkg;

    localparam int HV_W   = 9;
    localparam int HV_MAX = (1 << HV_W) - 1;

    typedef logic [HV_W-1:0] hv_t;

    // RP2C02 (NTSC) raster
    localparam int NTSC_H_TOTAL     = 341;
    localparam int NTSC_V_TOTAL     = 262;
    localparam int NTSC_H_VISIBLE   = 256;
    localparam int NTSC_V_VISIBLE   = 240;
    localparam int NTSC_HSYNC_START = 280;
    localparam int NTSC_HSYNC_LEN   = 25;
    localparam int NTSC_BURST_START = 309;
    localparam int NTSC_BURST_LEN   = 15;
    localparam int NTSC_VSYNC_LINE  = 244;
    localparam int NTSC_VSYNC_LINES = 3;
    localparam int NTSC_ODD_SKIP    = 1;

    // RP2C07 (PAL) raster: longer frame, no odd-frame dot skip
    localparam int PAL_H_TOTAL      = 341;
    localparam int PAL_V_TOTAL      = 312;
    localparam int PAL_H_VISIBLE    = 256;
    localparam int PAL_V_VISIBLE    = 240;
    localparam int PAL_HSYNC_START  = 280;
    localparam int PAL_HSYNC_LEN    = 25;
    localparam int PAL_BURST_START  = 309;
    localparam int PAL_BURST_LEN    = 15;
    localparam int PAL_VSYNC_LINE   = 269;
    localparam int PAL_VSYNC_LINES  = 3;
    localparam int PAL_ODD_SKIP     = 0;

    // Half-open window test: lo <= x < hi
    function automatic logic in_window(input hv_t x, input hv_t lo, input hv_t hi);
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// H/V dot and line counters with frame parity and the odd-frame short-line rule.
module raster_counter
    import ppu_timing_pkg::*;
#(
    parameter int H_TOTAL  = NTSC_H_TOTAL,
    parameter int V_TOTAL  = NTSC_V_TOTAL,
    parameter int ODD_SKIP = NTSC_ODD_SKIP
) (
    input  logic            clk,
    input  logic            n_res,
    input  logic            pclk_en,
    input  logic            render_en,
    output logic [HV_W-1:0] h,
    output logic [HV_W-1:0] v,
    output logic            frame_odd
);

    localparam hv_t H_LAST  = hv_t'(H_TOTAL - 1);
    localparam hv_t H_SKIP  = hv_t'(H_TOTAL - 2);
    localparam hv_t V_LAST  = hv_t'(V_TOTAL - 1);
    localparam bit  SKIP_EN = (ODD_SKIP != 0);

    hv_t  h_reg;
    hv_t  v_reg;
    logic odd_reg;
    logic line_end;
    logic frame_end;

    // The last line of an odd rendered frame ends one dot early, jumping straight to (0,0).
    always_comb begin
        line_end  = (h_reg == H_LAST);
        frame_end = (v_reg == V_LAST) &&
                    (line_end || (SKIP_EN && odd_reg && render_en && (h_reg == H_SKIP)));
    end

    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            h_reg   <= '0;
            v_reg   <= '0;
            odd_reg <= 1'b0;
        end else if (pclk_en) begin
            if (frame_end) begin
                h_reg   <= '0;
                v_reg   <= '0;
                odd_reg <= ~odd_reg;
            end else if (line_end) begin
                h_reg <= '0;
                v_reg <= v_reg + hv_t'(1);
            end else begin
                h_reg <= h_reg + hv_t'(1);
            end
        end
    end

    assign h         = h_reg;
    assign v         = v_reg;
    assign frame_odd = odd_reg;

endmodule

// File: rtl/video_timing_sequencer.sv
// PPU video timing: raster counters plus registered SYNC/BURST/picture/VBLANK/phase-reset
// decode; every decoded output trails the H/V counters by one enabled dot.
module video_timing_sequencer
    import ppu_timing_pkg::*;
#(
    parameter int H_TOTAL     = NTSC_H_TOTAL,
    parameter int V_TOTAL     = NTSC_V_TOTAL,
    parameter int H_VISIBLE   = NTSC_H_VISIBLE,
    parameter int V_VISIBLE   = NTSC_V_VISIBLE,
    parameter int HSYNC_START = NTSC_HSYNC_START,
    parameter int HSYNC_LEN   = NTSC_HSYNC_LEN,
    parameter int BURST_START = NTSC_BURST_START,
    parameter int BURST_LEN   = NTSC_BURST_LEN,
    parameter int VSYNC_LINE  = NTSC_VSYNC_LINE,
    parameter int VSYNC_LINES = NTSC_VSYNC_LINES,
    parameter int ODD_SKIP    = NTSC_ODD_SKIP
) (
    input  logic            CLK,
    input  logic            n_RES,
    input  logic            pclk_en,
    input  logic            render_en,
    output logic [HV_W-1:0] H,
    output logic [HV_W-1:0] V,
    output logic            SYNC,
    output logic            BURST,
    output logic            n_PICTURE,
    output logic            V0,
    output logic            PH_RES,
    output logic            VBLANK,
    output logic            FRAME_ODD,
    output logic            frame_start
);

    localparam bit PARAMS_OK =
        (H_TOTAL >= 3) && (H_TOTAL <= HV_MAX) &&
        (V_TOTAL >= 3) && (V_TOTAL <= HV_MAX) &&
        (H_VISIBLE <= H_TOTAL) && (V_VISIBLE + 1 < V_TOTAL) &&
        (HSYNC_LEN > 0) && (BURST_LEN >= 0) && (VSYNC_LINES >= 0) &&
        (HSYNC_START + HSYNC_LEN < H_TOTAL) &&
        (BURST_START + BURST_LEN < H_TOTAL) &&
        ((HSYNC_START + HSYNC_LEN <= BURST_START) || (BURST_START + BURST_LEN <= HSYNC_START)) &&
        (VSYNC_LINE + VSYNC_LINES < V_TOTAL) &&
        ((ODD_SKIP == 0) || (ODD_SKIP == 1));

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("video_timing_sequencer: illegal timing parameter set");
        end
    endgenerate

    localparam hv_t HS_LO  = hv_t'(HSYNC_START);
    localparam hv_t HS_HI  = hv_t'(HSYNC_START + HSYNC_LEN);
    localparam hv_t BU_LO  = hv_t'(BURST_START);
    localparam hv_t BU_HI  = hv_t'(BURST_START + BURST_LEN);
    localparam hv_t VS_LO  = hv_t'(VSYNC_LINE);
    localparam hv_t VS_HI  = hv_t'(VSYNC_LINE + VSYNC_LINES);
    localparam hv_t H_VIS  = hv_t'(H_VISIBLE);
    localparam hv_t V_VIS  = hv_t'(V_VISIBLE);
    localparam hv_t VB_SET = hv_t'(V_VISIBLE + 1);
    localparam hv_t V_LAST = hv_t'(V_TOTAL - 1);

    hv_t  h;
    hv_t  v;
    logic frame_odd;

    raster_counter #(
        .H_TOTAL  (H_TOTAL),
        .V_TOTAL  (V_TOTAL),
        .ODD_SKIP (ODD_SKIP)
    ) u_raster (
        .clk       (CLK),
        .n_res     (n_RES),
        .pclk_en   (pclk_en),
        .render_en (render_en),
        .h         (h),
        .v         (v),
        .frame_odd (frame_odd)
    );

    logic vs, hs, bw, home, vb_set, vb_clr;
    logic sync_next, burst_next, npic_next;

    always_comb begin
        vs         = in_window(v, VS_LO, VS_HI);
        hs         = in_window(h, HS_LO, HS_HI);
        bw         = in_window(h, BU_LO, BU_HI);
        // Vertical sync lines carry inverted (serrated) horizontal pulses.
        sync_next  = vs ? ~hs : hs;
        burst_next = ~vs & bw;
        npic_next  = ~((h < H_VIS) && (v < V_VIS));
        home       = (h == '0) && (v == '0);
        vb_set     = (h == hv_t'(1)) && (v == VB_SET);
        vb_clr     = (h == hv_t'(1)) && (v == V_LAST);
    end

    logic sync_reg, burst_reg, npic_reg, v0_reg, ph_res_reg, vblank_reg, fs_reg;

    // PH_RES resets high and then follows the (0,0) decode, so it stays high through the
    // first enabled edge (which leaves dot 0,0) and then pulses once per frame.
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            sync_reg   <= 1'b0;
            burst_reg  <= 1'b0;
            npic_reg   <= 1'b1;
            v0_reg     <= 1'b0;
            ph_res_reg <= 1'b1;
            vblank_reg <= 1'b0;
            fs_reg     <= 1'b0;
        end else if (pclk_en) begin
            sync_reg   <= sync_next;
            burst_reg  <= burst_next;
            npic_reg   <= npic_next;
            v0_reg     <= v[0];
            ph_res_reg <= home;
            fs_reg     <= home;
            if (vb_clr) begin
                vblank_reg <= 1'b0;
            end else if (vb_set) begin
                vblank_reg <= 1'b1;
            end
        end
    end

    assign H           = h;
    assign V           = v;
    assign FRAME_ODD   = frame_odd;
    assign SYNC        = sync_reg;
    assign BURST       = burst_reg;
    assign n_PICTURE   = npic_reg;
    assign V0          = v0_reg;
    assign PH_RES      = ph_res_reg;
    assign VBLANK      = vblank_reg;
    assign frame_start = fs_reg;

endmodule

// File: tb/tb_video_timing_sequencer.sv
// Directed bench: a default NTSC instance for reset and line-window checks, plus two
// shrunken rasters (40x20 dots, odd skip on / off) for frame-level timing checks.
module tb_video_timing_sequencer;

    logic clk = 1'b0;
    logic n_res = 1'b0;
    logic pclk_en = 1'b0;
    logic render_en = 1'b0;

    always #5 clk = ~clk;

    logic [8:0] n_h, n_v, s_h, s_v, p_h, p_v;
    logic n_sync, n_burst, n_npic, n_v0, n_phres, n_vblank, n_odd, n_fs;
    logic s_sync, s_burst, s_npic, s_v0, s_phres, s_vblank, s_odd, s_fs;
    logic p_sync, p_burst, p_npic, p_v0, p_phres, p_vblank, p_odd, p_fs;

    int n_checks = 0;
    int n_fail   = 0;

    video_timing_sequencer dut_ntsc (
        .CLK(clk), .n_RES(n_res), .pclk_en(pclk_en), .render_en(render_en),
        .H(n_h), .V(n_v), .SYNC(n_sync), .BURST(n_burst), .n_PICTURE(n_npic),
        .V0(n_v0), .PH_RES(n_phres), .VBLANK(n_vblank), .FRAME_ODD(n_odd),
        .frame_start(n_fs)
    );

    video_timing_sequencer #(
        .H_TOTAL(40), .V_TOTAL(20), .H_VISIBLE(16), .V_VISIBLE(12),
        .HSYNC_START(20), .HSYNC_LEN(5), .BURST_START(28), .BURST_LEN(6),
        .VSYNC_LINE(14), .VSYNC_LINES(3), .ODD_SKIP(1)
    ) dut_small (
        .CLK(clk), .n_RES(n_res), .pclk_en(pclk_en), .render_en(render_en),
        .H(s_h), .V(s_v), .SYNC(s_sync), .BURST(s_burst), .n_PICTURE(s_npic),
        .V0(s_v0), .PH_RES(s_phres), .VBLANK(s_vblank), .FRAME_ODD(s_odd),
        .frame_start(s_fs)
    );

    video_timing_sequencer #(
        .H_TOTAL(40), .V_TOTAL(20), .H_VISIBLE(16), .V_VISIBLE(12),
        .HSYNC_START(20), .HSYNC_LEN(5), .BURST_START(28), .BURST_LEN(6),
        .VSYNC_LINE(14), .VSYNC_LINES(3), .ODD_SKIP(0)
    ) dut_pal (
        .CLK(clk), .n_RES(n_res), .pclk_en(pclk_en), .render_en(render_en),
        .H(p_h), .V(p_v), .SYNC(p_sync), .BURST(p_burst), .n_PICTURE(p_npic),
        .V0(p_v0), .PH_RES(p_phres), .VBLANK(p_vblank), .FRAME_ODD(p_odd),
        .frame_start(p_fs)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_res = 1'b0;
        step();
        step();
        n_res = 1'b1;
    endtask

    task automatic wait_small(input logic [8:0] vv, input logic [8:0] hh, input int budget,
                              output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (s_v == vv && s_h == hh) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        pclk_en   = 1'b1;
        render_en = 1'b1;
        n_res     = 1'b0;
        step();
        step();
        n_checks++;
        if ({n_h, n_v} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_counters: H=%0d V=%0d, expected 0 0", n_h, n_v);
        end
        n_checks++;
        if ({n_sync, n_burst, n_npic, n_v0, n_phres, n_vblank, n_odd, n_fs} !== 8'b0010_1000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, expected 00101000",
                     {n_sync, n_burst, n_npic, n_v0, n_phres, n_vblank, n_odd, n_fs});
        end
        $display("reset: H=%0d V=%0d PH_RES=%b n_PICTURE=%b", n_h, n_v, n_phres, n_npic);
    endtask

    task automatic test_first_dots();
        n_res = 1'b1;
        step();
        n_checks++;
        if ({n_h, n_phres, n_npic, n_fs} !== {9'd1, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL dot1: H=%0d PH_RES=%b n_PICTURE=%b frame_start=%b, expected 1 1 0 1",
                     n_h, n_phres, n_npic, n_fs);
        end
        step();
        n_checks++;
        if ({n_h, n_phres, n_npic, n_fs} !== {9'd2, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL dot2: H=%0d PH_RES=%b n_PICTURE=%b frame_start=%b, expected 2 0 0 0",
                     n_h, n_phres, n_npic, n_fs);
        end
        step();
        n_checks++;
        if ({n_h, n_phres, n_sync} !== {9'd3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL dot3: H=%0d PH_RES=%b SYNC=%b, expected 3 0 0", n_h, n_phres, n_sync);
        end
        $display("first dots: H=%0d PH_RES=%b", n_h, n_phres);
    endtask

    task automatic test_line_windows();
        int sync_cnt = 0, burst_cnt = 0, overlap = 0;
        int sync_first = -1, sync_last = -1, burst_first = -1, burst_last = -1;
        logic npic256 = 1'bx, npic257 = 1'bx;
        logic reached = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (n_v == 9'd1) begin
                reached = 1'b1;
                break;
            end
            if (n_sync) begin
                sync_cnt++;
                if (sync_first < 0) sync_first = int'(n_h);
                sync_last = int'(n_h);
            end
            if (n_burst) begin
                burst_cnt++;
                if (burst_first < 0) burst_first = int'(n_h);
                burst_last = int'(n_h);
            end
            if (n_sync && n_burst) overlap++;
            if (n_h == 9'd256) npic256 = n_npic;
            if (n_h == 9'd257) npic257 = n_npic;
        end
        n_checks++;
        if (!reached) begin
            n_fail++;
            $display("FAIL line_wrap: V stayed %0d, expected wrap to line 1 within 400 dots", n_v);
        end
        n_checks++;
        if (sync_cnt != 25 || sync_first != 281 || sync_last != 305) begin
            n_fail++;
            $display("FAIL hsync_window: count=%0d first=%0d last=%0d, expected 25 281 305",
                     sync_cnt, sync_first, sync_last);
        end
        n_checks++;
        if (burst_cnt != 15 || burst_first != 310 || burst_last != 324) begin
            n_fail++;
            $display("FAIL burst_window: count=%0d first=%0d last=%0d, expected 15 310 324",
                     burst_cnt, burst_first, burst_last);
        end
        n_checks++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL sync_burst_overlap: %0d dots, expected 0", overlap);
        end
        n_checks++;
        if ({npic256, npic257} !== 2'b01) begin
            n_fail++;
            $display("FAIL picture_edge: n_PICTURE@256=%b @257=%b, expected 0 1", npic256, npic257);
        end
        $display("line 0: sync %0d..%0d burst %0d..%0d", sync_first, sync_last, burst_first, burst_last);
    endtask

    task automatic test_vsync_lines();
        logic ok;
        int mism = 0, low_cnt = 0, burst_cnt = 0, next_sync = 0;
        pclk_en = 1'b1;
        do_reset();
        wait_small(9'd1, 9'd0, 100, ok);
        n_checks++;
        if (!ok || s_v0 !== 1'b0) begin
            n_fail++;
            $display("FAIL v0_lag_a: reached=%b V0=%b, expected 1 0", ok, s_v0);
        end
        step();
        n_checks++;
        if (s_v0 !== 1'b1) begin
            n_fail++;
            $display("FAIL v0_lag_b: V0=%b, expected 1", s_v0);
        end
        wait_small(9'd14, 9'd0, 1000, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL vsync_reach: H=%0d V=%0d, expected 0 14", s_h, s_v);
        end
        for (int k = 0; k < 120; k++) begin
            step();
            if (s_sync !== !((k % 40) >= 20 && (k % 40) <= 24)) mism++;
            if (s_sync === 1'b0) low_cnt++;
            if (s_burst === 1'b1) burst_cnt++;
        end
        for (int k = 0; k < 40; k++) begin
            step();
            if (s_sync === 1'b1) next_sync++;
        end
        n_checks++;
        if (mism != 0 || low_cnt != 15) begin
            n_fail++;
            $display("FAIL vsync_serration: mismatches=%0d low=%0d, expected 0 15", mism, low_cnt);
        end
        n_checks++;
        if (burst_cnt != 0) begin
            n_fail++;
            $display("FAIL vsync_burst: %0d burst dots, expected 0", burst_cnt);
        end
        n_checks++;
        if (next_sync != 5) begin
            n_fail++;
            $display("FAIL post_vsync_line: %0d sync dots, expected 5", next_sync);
        end
        $display("vsync lines: low=%0d burst=%0d next line sync=%0d", low_cnt, burst_cnt, next_sync);
    endtask

    task automatic test_frames(input logic ren);
        int s_at[3] = '{0, 0, 0};
        int p_at[3] = '{0, 0, 0};
        int s_n = 0, p_n = 0;
        logic odd_at_2nd = 1'b0;
        render_en = ren;
        pclk_en   = 1'b1;
        do_reset();
        for (int i = 1; i <= 1700; i++) begin
            step();
            if (s_fs && s_n < 3) begin
                s_at[s_n] = i;
                if (s_n == 1) odd_at_2nd = s_odd;
                s_n++;
            end
            if (p_fs && p_n < 3) begin
                p_at[p_n] = i;
                p_n++;
            end
        end
        n_checks++;
        if (s_n != 3 || s_at[1] - s_at[0] != 800 || s_at[2] - s_at[1] != (ren ? 799 : 800)) begin
            n_fail++;
            $display("FAIL frame_len_skip(ren=%b): pulses=%0d len0=%0d len1=%0d, expected 3 800 %0d",
                     ren, s_n, s_at[1] - s_at[0], s_at[2] - s_at[1], ren ? 799 : 800);
        end
        n_checks++;
        if (p_n != 3 || p_at[1] - p_at[0] != 800 || p_at[2] - p_at[1] != 800) begin
            n_fail++;
            $display("FAIL frame_len_noskip(ren=%b): pulses=%0d len0=%0d len1=%0d, expected 3 800 800",
                     ren, p_n, p_at[1] - p_at[0], p_at[2] - p_at[1]);
        end
        n_checks++;
        if (s_at[0] != 1 || odd_at_2nd !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_parity: first pulse=%0d FRAME_ODD@2nd=%b, expected 1 1",
                     s_at[0], odd_at_2nd);
        end
        $display("frames ren=%b: skip %0d/%0d noskip %0d/%0d", ren,
                 s_at[1] - s_at[0], s_at[2] - s_at[1], p_at[1] - p_at[0], p_at[2] - p_at[1]);
    endtask

    task automatic test_vblank(input logic rnd);
        int en = 0, rise_at = -1, fall_at = -1, fs2_at = -1, hold_err = 0;
        logic prev = 1'b0;
        logic [8:0] h_before;
        render_en = 1'b0;
        pclk_en   = 1'b1;
        do_reset();
        for (int i = 0; i < 4000 && en < 805; i++) begin
            pclk_en  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            h_before = s_h;
            step();
            if (pclk_en) en++;
            else if (s_h !== h_before) hold_err++;
            if (s_vblank !== prev) begin
                if (s_vblank === 1'b1) rise_at = en;
                else fall_at = en;
                prev = s_vblank;
            end
            if (s_fs && en > 1 && fs2_at < 0) fs2_at = en;
        end
        pclk_en = 1'b1;
        n_checks++;
        if (rise_at != 522 || fall_at != 762) begin
            n_fail++;
            $display("FAIL vblank_edges(rnd=%b): rise=%0d fall=%0d, expected 522 762", rnd, rise_at, fall_at);
        end
        n_checks++;
        if (fs2_at != 801 || hold_err != 0) begin
            n_fail++;
            $display("FAIL enable_gating(rnd=%b): 2nd frame_start=%0d holds broken=%0d, expected 801 0",
                     rnd, fs2_at, hold_err);
        end
        $display("vblank rnd=%b: rise=%0d fall=%0d frame=%0d", rnd, rise_at, fall_at, fs2_at);
    endtask

    task automatic test_midframe_reset(input logic [8:0] hh, input logic want_burst);
        logic ok;
        int pulses = 0, first_at = -1, second_at = -1;
        pclk_en = 1'b1;
        do_reset();
        wait_small(9'd5, hh, 1000, ok);
        n_checks++;
        if (!ok || (want_burst ? s_burst : s_sync) !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_setup(H=%0d): reached=%b SYNC=%b BURST=%b, expected pulse high",
                     hh, ok, s_sync, s_burst);
        end
        #3 n_res = 1'b0;
        #1;
        n_checks++;
        if ({s_h, s_v} !== 18'd0 ||
            {s_sync, s_burst, s_npic, s_v0, s_phres, s_vblank, s_odd, s_fs} !== 8'b0010_1000) begin
            n_fail++;
            $display("FAIL async_reset(H=%0d): H=%0d V=%0d flags=%b, expected 0 0 00101000", hh, s_h, s_v,
                     {s_sync, s_burst, s_npic, s_v0, s_phres, s_vblank, s_odd, s_fs});
        end
        step();
        n_res = 1'b1;
        for (int i = 1; i <= 900; i++) begin
            step();
            if (s_fs) begin
                pulses++;
                if (first_at < 0) first_at = i;
                else if (second_at < 0) second_at = i;
            end
        end
        n_checks++;
        if (pulses != 2 || first_at != 1 || second_at != 801) begin
            n_fail++;
            $display("FAIL post_reset_frame: pulses=%0d at %0d,%0d, expected 2 at 1,801",
                     pulses, first_at, second_at);
        end
        $display("midframe reset at H=%0d: frame_start at %0d and %0d", hh, first_at, second_at);
    endtask

    initial begin
        test_reset();
        test_first_dots();
        test_line_windows();
        test_vsync_lines();
        test_frames(1'b1);
        test_frames(1'b0);
        test_vblank(1'b0);
        test_vblank(1'b1);
        test_midframe_reset(9'd22, 1'b0);
        test_midframe_reset(9'd30, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "time limit");
    end

endmodule
